mul_row_seq: RTL and testbench

MUL_ROW_SEQ -- requirements
Module: mul_row_seq

---
 rtl/mul_row_seq_if.sv | 52 +++++
 rtl/mul_row_seq.sv | 91 +++++++++
 tb/tb_mul_row_seq.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mul_row_seq_if.sv
// Bundle of row-engine signals: control, A/T memory ports, multiply-add cell ports, status.
// cin_init exists only when MUL_ROW_CARRY_IN_EN is defined.
`timescale 1ns/1ps
interface mul_row_seq_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 6
);
  logic                  start;
  logic [ADDR_WIDTH:0]   len;
  logic [DATA_WIDTH-1:0] b;
`ifdef MUL_ROW_CARRY_IN_EN
  logic [DATA_WIDTH-1:0] cin_init;
`endif
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [ADDR_WIDTH-1:0] t_addr;
  logic [DATA_WIDTH-1:0] a_rdata;
  logic [DATA_WIDTH-1:0] t_rdata;
  logic                  t_we;
  logic [ADDR_WIDTH-1:0] t_waddr;
  logic [DATA_WIDTH-1:0] t_wdata;
  logic [DATA_WIDTH-1:0] mac_x;
  logic [DATA_WIDTH-1:0] mac_y;
  logic [DATA_WIDTH-1:0] mac_z;
  logic [DATA_WIDTH-1:0] mac_cin;
  logic [DATA_WIDTH-1:0] mac_s;
  logic [DATA_WIDTH-1:0] mac_cout;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] carry_out;

  // Controller / environment side
  modport master (
    output start, len, b,
`ifdef MUL_ROW_CARRY_IN_EN
    output cin_init,
`endif
    output a_rdata, t_rdata, mac_s, mac_cout,
    input  a_addr, t_addr, t_we, t_waddr, t_wdata,
    input  mac_x, mac_y, mac_z, mac_cin, busy, done, carry_out
  );

  // Row engine side
  modport slave (
    input  start, len, b,
`ifdef MUL_ROW_CARRY_IN_EN
    input  cin_init,
`endif
    input  a_rdata, t_rdata, mac_s, mac_cout,
    output a_addr, t_addr, t_we, t_waddr, t_wdata,
    output mac_x, mac_y, mac_z, mac_cin, busy, done, carry_out
  );
endinterface

// File: rtl/mul_row_seq.sv
// Row multiply-accumulate sequencer: {c, T[j]} = A[j]*b + T[j] + c over one row.
// Define MUL_ROW_CARRY_IN_EN to seed the row carry from cin_init instead of zero.
`timescale 1ns/1ps
module mul_row_seq #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 6
) (
  input logic          clk,
  input logic          rst_n,
  mul_row_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FETCH, CALC, FIN} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH:0]   r_j;
  logic [ADDR_WIDTH:0]   r_len;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_c;
  logic [DATA_WIDTH-1:0] r_carry_out;
  logic                  r_done;

  logic                  w_fetch;
  logic                  w_calc;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_c_seed;

`ifdef MUL_ROW_CARRY_IN_EN
  assign w_c_seed = bus.cin_init;
`else
  assign w_c_seed = '0;
`endif

  assign w_fetch = (r_state == FETCH);
  assign w_calc  = (r_state == CALC);
  // j and len are one bit wider than the address so a full 2^ADDR_WIDTH row terminates cleanly
  assign w_last  = (r_j == r_len - (ADDR_WIDTH+1)'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_j         <= '0;
      r_len       <= '0;
      r_b         <= '0;
      r_c         <= '0;
      r_carry_out <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_len   <= bus.len;
            r_b     <= bus.b;
            r_c     <= w_c_seed;
            r_j     <= '0;
            r_state <= (bus.len == '0) ? FIN : FETCH;
          end
        end
        FETCH: r_state <= CALC;
        CALC: begin
          r_c <= bus.mac_cout;
          if (w_last) begin
            r_state <= FIN;
          end else begin
            r_j     <= r_j + (ADDR_WIDTH+1)'(1);
            r_state <= FETCH;
          end
        end
        FIN: begin
          r_done      <= 1'b1;
          r_carry_out <= r_c;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  // Datapath outputs decode the state register so reset silences them immediately
  assign bus.a_addr    = w_fetch ? r_j[ADDR_WIDTH-1:0] : '0;
  assign bus.t_addr    = w_fetch ? r_j[ADDR_WIDTH-1:0] : '0;
  assign bus.t_we      = w_calc;
  assign bus.t_waddr   = w_calc ? r_j[ADDR_WIDTH-1:0] : '0;
  assign bus.t_wdata   = w_calc ? bus.mac_s : '0;
  assign bus.mac_x     = w_calc ? bus.a_rdata : '0;
  assign bus.mac_y     = w_calc ? r_b : '0;
  assign bus.mac_z     = w_calc ? bus.t_rdata : '0;
  assign bus.mac_cin   = w_calc ? r_c : '0;
  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = r_done;
  assign bus.carry_out = r_carry_out;
endmodule

// File: tb/tb_mul_row_seq.sv
// Self-checking bench for mul_row_seq: vector table, write scoreboard, mid-row start and reset sequences.
`timescale 1ns/1ps
module tb_mul_row_seq;
  localparam int DW = 64;
  localparam int AW = 6;
  localparam int NW = 64;
  typedef logic [DW-1:0] word_t;
  localparam word_t ALL1 = '1;
  localparam word_t SENT = 64'hDEAD_BEEF_0000_0000;

  typedef struct {
    int unsigned len;
    word_t       b;
    int unsigned amode;   // 0: A[j]=aval, 1: A[j]=j+aval
    word_t       aval;
    word_t       tval;
    word_t       exp_carry;
    int unsigned exp_lat;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    word_t         data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load = 1'b0;
  always #5 clk = ~clk;

  mul_row_seq_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();
  mul_row_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  word_t mem_a [NW];
  word_t mem_t [NW];
  word_t init_a[NW];
  word_t init_t[NW];
  wr_t   sbq[$];
  int    tests = 0;
  int    fails = 0;
  int    wr_count = 0;

  // Environment: synchronous-read memories and a combinational multiply-add cell
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < NW; i++) begin
        mem_a[i] <= init_a[i];
        mem_t[i] <= init_t[i];
      end
    end else begin
      bus.a_rdata <= mem_a[bus.a_addr];
      bus.t_rdata <= mem_t[bus.t_addr];
      if (bus.t_we) mem_t[bus.t_waddr] <= bus.t_wdata;
    end
  end

  logic [2*DW-1:0] mac_full;
  assign mac_full = (2*DW)'(bus.mac_x) * (2*DW)'(bus.mac_y)
                  + (2*DW)'(bus.mac_z) + (2*DW)'(bus.mac_cin);
  assign bus.mac_s    = mac_full[DW-1:0];
  assign bus.mac_cout = mac_full[2*DW-1:DW];
`ifdef MUL_ROW_CARRY_IN_EN
  assign bus.cin_init = '0;
`endif

  // Scoreboard: every observed write must match the next expected write
  always @(negedge clk) begin
    if (rst_n && bus.t_we) begin
      wr_count++;
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: addr=%0d data=%h, expected no write", bus.t_waddr, bus.t_wdata);
      end else begin
        wr_t e;
        e = sbq.pop_front();
        if (bus.t_waddr !== e.addr || bus.t_wdata !== e.data) begin
          fails++;
          $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   bus.t_waddr, bus.t_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic check(input string name, input word_t act, input word_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic load_mems(input vec_t v, output word_t exp_t[NW]);
    for (int i = 0; i < NW; i++) begin
      init_a[i] = (v.amode == 1) ? word_t'(i) + v.aval : v.aval;
      init_t[i] = (i < int'(v.len)) ? v.tval : (SENT ^ word_t'(i));
      exp_t[i]  = init_t[i];
    end
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  // Push expected writes for words 0..n-1 and update the expected T image
  task automatic predict(input vec_t v, input int unsigned n, inout word_t exp_t[NW]);
    word_t c;
    logic [2*DW-1:0] acc;
    c = '0;
    for (int j = 0; j < int'(n); j++) begin
      acc = (2*DW)'(init_a[j]) * (2*DW)'(v.b) + (2*DW)'(init_t[j]) + (2*DW)'(c);
      exp_t[j] = acc[DW-1:0];
      c = acc[2*DW-1:DW];
      sbq.push_back('{addr: AW'(j), data: exp_t[j]});
    end
  endtask

  task automatic check_mem(input string name, input word_t exp_t[NW]);
    int bad;
    int first;
    bad = 0;
    first = -1;
    for (int i = 0; i < NW; i++) begin
      if (mem_t[i] !== exp_t[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    if (first >= 0)
      $display("  first bad T word %0d: got %h, expected %h", first, mem_t[first], exp_t[first]);
    check(name, word_t'(bad), 0);
  endtask

  task automatic run_vec(input vec_t v, input bit inject);
    word_t exp_t[NW];
    int unsigned cyc;
    bit seen;
    load_mems(v, exp_t);
    predict(v, v.len, exp_t);
    wr_count = 0;
    bus.start = 1'b1;
    bus.len   = (AW+1)'(v.len);
    bus.b     = v.b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_after_start", word_t'(bus.busy), 1);
    cyc = 0;
    seen = 0;
    while (!seen && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (inject && cyc == 3) begin
        bus.start = 1'b1; bus.len = (AW+1)'(2); bus.b = 64'd99;
      end
      if (inject && cyc == 4) bus.start = 1'b0;
      if (bus.done) seen = 1;
    end
    check("done_latency", word_t'(cyc), word_t'(v.exp_lat));
    check("carry_out", bus.carry_out, v.exp_carry);
    check("busy_at_done", word_t'(bus.busy), 0);
    @(posedge clk); #1;
    check("done_pulse_width", word_t'(bus.done), 0);
    check("carry_out_held", bus.carry_out, v.exp_carry);
    check("idle_after_done", word_t'(bus.busy), 0);
    check("write_count", word_t'(wr_count), word_t'(v.len));
    check("sb_drained", word_t'(sbq.size()), 0);
    sbq.delete();
    check_mem("t_mem", exp_t);
  endtask

  vec_t vecs[7];

  initial begin
    word_t exp_t[NW];
    vec_t  rv;
    bit    found;
    vecs[0] = '{1,  64'd3,  0, 64'd2, 64'd5, 64'd0, 3};
    vecs[1] = '{1,  ALL1,   0, ALL1,  ALL1,  ALL1,  3};
    vecs[2] = '{64, 64'd2,  1, 64'd0, 64'd0, 64'd0, 129};
    vecs[3] = '{0,  64'd7,  0, 64'd4, 64'd9, 64'd0, 1};
    vecs[4] = '{3,  ALL1,   0, ALL1,  ALL1,  ALL1,  7};
    vecs[5] = '{5,  64'd10, 1, 64'd1, 64'd7, 64'd0, 11};
    vecs[6] = '{2,  64'd2,  0, ALL1,  64'd0, 64'd1, 5};

    bus.start = 1'b0;
    bus.len   = '0;
    bus.b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",      word_t'(bus.busy), 0);
    check("rst_done",      word_t'(bus.done), 0);
    check("rst_t_we",      word_t'(bus.t_we), 0);
    check("rst_a_addr",    word_t'(bus.a_addr), 0);
    check("rst_mac_y",     bus.mac_y, 0);
    check("rst_carry_out", bus.carry_out, 0);
    @(negedge clk); rst_n = 1'b1;

    for (int k = 0; k < 7; k++) run_vec(vecs[k], 1'b0);
    run_vec(vecs[5], 1'b1);

    // Reset asserted while the engine is writing word 3 of an 8-word row
    rv = '{8, 64'd5, 1, 64'd1, 64'd100, 64'd0, 17};
    load_mems(rv, exp_t);
    predict(rv, 3, exp_t);
    bus.start = 1'b1; bus.len = (AW+1)'(8); bus.b = rv.b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    found = 0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(posedge clk); #2;
      if (bus.t_we && bus.t_waddr == AW'(3)) found = 1;
    end
    check("reached_calc_j3", word_t'(found), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_t_we",    word_t'(bus.t_we), 0);
    check("mid_rst_busy",    word_t'(bus.busy), 0);
    check("mid_rst_done",    word_t'(bus.done), 0);
    check("mid_rst_t_addr",  word_t'(bus.t_addr), 0);
    check("mid_rst_mac_cin", bus.mac_cin, 0);
    check("mid_rst_carry",   bus.carry_out, 0);
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_sb", word_t'(sbq.size()), 0);
    sbq.delete();
    check_mem("mid_rst_t_mem", exp_t);
    @(negedge clk); rst_n = 1'b1;

    run_vec(vecs[0], 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
